// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-wide constants and types for the 19-bit pipelined CPU.
// Used by the register file, the decode and control blocks, and immediate
// extension.
//   WIDTH      datapath width (19)
//   ADDR_W     register address width (3)
//   NUM_REGS   architectural register count (8 = 2**ADDR_W)
//   word_t     one datapath word
//   reg_addr_t one register index
package cpu_pkg;
    localparam int WIDTH    = 19;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_wr_decode.sv
// regfile_wr_decode: one-hot write decoder for the register file. It gates
// the write enable into one enable per register.
// Ports:
//   en   in   write enable (regwriteW)
//   addr in   destination register index
//   sel  out  one-hot per-register write enable; all zero when en=0
module regfile_wr_decode
    import cpu_pkg::*;
#(
    parameter int A_W = cpu_pkg::ADDR_W,
    parameter int N   = cpu_pkg::NUM_REGS
) (
    input  logic           en,
    input  logic [A_W-1:0] addr,
    output logic [N-1:0]   sel
);

    for (genvar i = 0; i < N; i++) begin : g_sel
        assign sel[i] = en && (addr == A_W'(i));
    end

endmodule

// File: rtl/register_file.sv
// register_file: 8 x 19-bit general-purpose register file. It has two
// combinational read ports and one synchronous write port. Register 0 is an
// ordinary register.
// Ports:
//   clk       in   clock; writes happen on the rising edge
//   rst       in   asynchronous active-low reset; clears every register
//   wE3       in   write enable from writeback
//   A1, A2    in   read addresses
//   A3        in   write address
//   wD3       in   write data
//   RD1, RD2  out  read data (zero-cycle latency)
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a write in
// flight forwards to a read port with a matching address in the same cycle.
// When it is undefined, a read in the same cycle as a write to the same
// address returns the old value.
module register_file
    import cpu_pkg::*;
#(
    parameter int WIDTH    = cpu_pkg::WIDTH,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS   // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wE3,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [WIDTH-1:0]  wD3,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2
);

    logic [NUM_REGS-1:0]            wr_sel;
    logic [NUM_REGS-1:0][WIDTH-1:0] regs;

    regfile_wr_decode #(.A_W(ADDR_W), .N(NUM_REGS)) u_wr_decode (
        .en   (wE3),
        .addr (A3),
        .sel  (wr_sel)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                regs[i] <= '0;
            else if (wr_sel[i])
                regs[i] <= wD3;
        end
    end

    // Addresses cover exactly NUM_REGS entries, so these indexes never go
    // out of range. While reset is held, every entry is zero, so no extra
    // gating is needed on the stored path.
`ifdef REGFILE_BYPASS_EN
    always_comb begin
        RD1 = regs[A1];
        RD2 = regs[A2];
        if (rst && wE3 && (A3 == A1)) RD1 = wD3;
        if (rst && wE3 && (A3 == A2)) RD2 = wD3;
    end
`else
    assign RD1 = regs[A1];
    assign RD2 = regs[A2];
`endif

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
    localparam int W = 19;

    logic         clk = 1'b0;
    logic         rst;
    logic         wE3;
    logic [2:0]   A1, A2, A3;
    logic [W-1:0] wD3;
    logic [W-1:0] RD1, RD2;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] mdl [8];

    register_file dut (
        .clk (clk), .rst (rst), .wE3 (wE3),
        .A1 (A1), .A2 (A2), .A3 (A3),
        .wD3 (wD3), .RD1 (RD1), .RD2 (RD2)
    );

    always #5 clk = ~clk;

    // Reference model: an array of words. Reset clears it, and an enabled
    // edge stores one word.
    always @(negedge rst) foreach (mdl[i]) mdl[i] = '0;
    always @(posedge clk) if (rst === 1'b1 && wE3 === 1'b1) mdl[A3] = wD3;

    function automatic logic [W-1:0] model_rd(input logic [2:0] a);
        if (rst !== 1'b1) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wE3 === 1'b1 && A3 == a) return wD3;
`endif
        return mdl[a];
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare the outputs against the model on every cycle.
    always @(negedge clk) begin
        chk("cyc_rd1", RD1, model_rd(A1));
        chk("cyc_rd2", RD2, model_rd(A2));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] rdw_exp;
        foreach (mdl[i]) mdl[i] = '0;
        rst = 1'b0; wE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; wD3 = '0;
        #1;
        // While reset is held, every address reads zero.
        for (int i = 0; i < 8; i++) begin
            A1 = 3'(i); A2 = 3'(7 - i); #1;
            chk("rst_rd1", RD1, 19'h0);
            chk("rst_rd2", RD2, 19'h0);
        end
        // Writes issued during reset are ignored.
        step(); wE3 = 1'b1; A3 = 3'd0; wD3 = 19'h7FFFF;
        step(); A1 = 3'd0; #1;
        chk("rst_wr_ignored", RD1, 19'h0);
        #2 rst = 1'b1;                      // release mid-cycle

        // Write every register, then read each one back on both ports.
        for (int i = 0; i < 8; i++) begin
            step(); wE3 = 1'b1; A3 = 3'(i); wD3 = 19'h10000 + 19'(i);
        end
        step(); wE3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            A1 = 3'(i); A2 = 3'(7 - i); #1;
            chk("wr_all_rd1", RD1, 19'h10000 + 19'(i));
            chk("wr_all_rd2", RD2, 19'h10007 - 19'(i));
        end

        // With the write disabled, register 3 keeps its value.
        wE3 = 1'b0; A3 = 3'd3; wD3 = 19'h7FFFF;
        step(); A1 = 3'd3; #1;
        chk("wr_disable", RD1, 19'h10003);

        // Both read ports may use the same address.
        wE3 = 1'b1; A3 = 3'd5; wD3 = 19'h2AAAA;
        step(); wE3 = 1'b0; A1 = 3'd5; A2 = 3'd5; #1;
        chk("same_addr_rd1", RD1, 19'h2AAAA);
        chk("same_addr_rd2", RD2, 19'h2AAAA);

        // Read during a write to the same address.
        wE3 = 1'b1; A3 = 3'd2; wD3 = 19'h00011;
        step(); A1 = 3'd2; A3 = 3'd2; wD3 = 19'h00022; wE3 = 1'b1; #1;
`ifdef REGFILE_BYPASS_EN
        rdw_exp = 19'h00022;
`else
        rdw_exp = 19'h00011;
`endif
        chk("rdw_same_cycle", RD1, rdw_exp);
        step(); wE3 = 1'b0; #1;
        chk("rdw_next_cycle", RD1, 19'h00022);

        // Register 0 holds the maximum value without truncation.
        wE3 = 1'b1; A3 = 3'd0; wD3 = 19'h7FFFF;
        step(); wE3 = 1'b0; A2 = 3'd0; #1;
        chk("max_reg0", RD2, 19'h7FFFF);

        // Random traffic with occasional mid-cycle resets.
        for (int n = 0; n < 600; n++) begin
            step();
            wE3 = 1'($urandom_range(0, 1));
            A1  = 3'($urandom_range(0, 7));
            A2  = ($urandom_range(0, 3) == 0) ? A1 : 3'($urandom_range(0, 7));
            A3  = ($urandom_range(0, 2) == 0) ? A1 : 3'($urandom_range(0, 7));
            wD3 = 19'($urandom);
            if ($urandom_range(0, 60) == 0) begin
                #1 rst = 1'b0;
                #1 rst = 1'b1;
            end
        end

        // Asserting reset mid-cycle clears the outputs without a clock edge.
        step(); wE3 = 1'b1; A3 = 3'd4; wD3 = 19'h12345;
        step(); wE3 = 1'b0; A1 = 3'd4; A2 = 3'd4; #1;
        chk("pre_async_rst", RD1, 19'h12345);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_rd1", RD1, 19'h0);
        chk("async_rst_rd2", RD2, 19'h0);
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural general-purpose register file for the 19-bit pipelined CPU.
- Sits in the decode stage: two combinational read ports feed operand registers RD1/RD2 into the D->E pipeline register.
- One synchronous write port, driven from the writeback stage (result, destination register, write enable).
- Eight 19-bit registers, all general purpose; there is no hardwired-zero register.

Parameters:
- WIDTH, 19, data width of each register and of all data ports.
- ADDR_W, 3, address width of A1/A2/A3.
- NUM_REGS, 8, register count; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- wE3  input  1  write enable from writeback (regwriteW).
- A1  input  ADDR_W  read address, port 1.
- A2  input  ADDR_W  read address, port 2.
- A3  input  ADDR_W  write address (rdW).
- wD3  input  WIDTH  write data (resultW).
- RD1  output  WIDTH  read data, port 1.
- RD2  output  WIDTH  read data, port 2.

Behaviour:
- Storage: NUM_REGS x WIDTH flops, indices 0..7.
- Reset: rst=0 asynchronously clears all registers to 19'd0, independent of clk. While rst=0, writes are ignored and RD1/RD2 read 0.
- Write: on a rising clk edge with rst=1 and wE3=1, reg[A3] <= wD3.
  - Register 0 is writable like every other register.
  - With wE3=0, no register changes.
- Read: RD1 = reg[A1], RD2 = reg[A2], purely combinational (zero-cycle latency), no clock involvement.
  - A1 == A2 is legal; both ports return the same value.
- Read-during-write, same address, same cycle (default build): the read returns the old value. The new value is visible from the cycle after the edge.
- Simultaneous writes cannot occur; there is a single write port.
- Reset release mid-cycle: the first write is captured on the first rising edge after rst goes high.
- X-safety: A1/A2/A3 are always in range because NUM_REGS = 2**ADDR_W; there is no out-of-range case.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass. If wE3=1 and A3==A1, RD1 = wD3 combinationally in the same cycle; likewise RD2 when A3==A2. This lets the decode stage see a writeback result in the same cycle. The bypass is suppressed while rst=0.
- Undefined: no bypass; RD1/RD2 reflect stored contents only (old value on same-cycle collision).

Decomposition:
- Shared package cpu_pkg: WIDTH (19), ADDR_W (3), NUM_REGS (8), and typedefs word_t (logic [18:0]) and reg_addr_t (logic [2:0]). The package is shared with the decode, control and immediate-extension blocks.
- One sub-module is natural: regfile_wr_decode, a one-hot 3-to-8 write decoder that gates wE3 into per-register enables.
- Read muxes stay inline in register_file.

Test Plan:
- Reset: hold rst=0, sweep A1/A2 over 0..7 -> RD1=RD2=0 for every address. Assert rst=0 asynchronously mid-cycle after writes -> outputs drop to 0 without a clock edge.
- Write/read all: rst=1, write reg[i]=19'h10000+i for i=0..7 (wE3=1) -> next cycle, A1=i gives 19'h10000+i and A2=7-i gives 19'h10007-i.
- Write disable: wE3=0, A3=3, wD3=19'h7FFFF, one edge -> reg[3] keeps its previous value 19'h10003.
- Same-address dual read: A1=A2=5 after writing 19'h2AAAA to reg[5] -> RD1=RD2=19'h2AAAA.
- Read-during-write: reg[2]=19'h00011; in one cycle set A1=2, A3=2, wE3=1, wD3=19'h00022.
  - Without REGFILE_BYPASS_EN: RD1=19'h00011 before the edge, 19'h00022 after.
  - With REGFILE_BYPASS_EN: RD1=19'h00022 immediately.
- Max value / register 0: write 19'h7FFFF to reg[0] -> RD2 at A2=0 reads 19'h7FFFF; no truncation or sign effects.
